// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with optional even/odd parity, timed by an oversample tick.
module uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_clk,
    input  logic       tx_en,
    input  logic       no_parity,
    input  logic       ev_parity,
    input  logic       tx_start,
    input  logic [7:0] txd_in,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    state_t     state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       no_par_q, no_par_d, par_bit_q, par_bit_d;
    logic       sample_clk_d_q;
    logic       txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic       adv, bit_end;

    assign adv     = sample_clk & ~sample_clk_d_q & tx_en;
    assign bit_end = adv && tick_cnt_q == LAST;
    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= 8'hFF;
            no_par_q       <= 1'b0;
            par_bit_q      <= 1'b0;
            sample_clk_d_q <= 1'b0;
            txd_q          <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            no_par_q       <= no_par_d;
            par_bit_q      <= par_bit_d;
            sample_clk_d_q <= sample_clk;
            txd_q          <= txd_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        no_par_d   = no_par_q;
        par_bit_d  = par_bit_q;
        if (!tx_en) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (state_q == IDLE) begin
            if (tx_start) begin
                state_d    = START;
                shift_d    = txd_in;
                no_par_d   = no_parity;
                par_bit_d  = ev_parity ? ^txd_in : ~^txd_in;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        end else if (adv) begin
            tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;
            if (bit_end) begin
                case (state_q)
                    START:   state_d = DATA;
                    DATA: begin
                        shift_d   = {1'b1, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = no_par_q ? STOP : PARITY;
                    end
                    PARITY:  state_d = STOP;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // txd is computed from the next state so the line changes on the same edge as the state
    always_comb begin
        txd_d  = state_d == START  ? 1'b0 :
                 state_d == DATA   ? shift_d[0] :
                 state_d == PARITY ? par_bit_d : 1'b1;
        busy_d = state_d != IDLE;
        done_d = tx_en && state_q == STOP && bit_end;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: sample_clk rising edges per bit period (legal range 4..16).
REQ-002 SHALL have port clk, input, 1: system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sample_clk, input, 1: oversample clock as a level, synchronous to clk.
REQ-005 SHALL have port tx_en, input, 1: transmitter enable.
REQ-006 SHALL have port no_parity, input, 1: 1 = no parity bit is sent.
REQ-007 SHALL have port ev_parity, input, 1: 1 = even parity, 0 = odd parity; ignored when no_parity=1.
REQ-008 SHALL have port tx_start, input, 1: one-clk request to send txd_in.
REQ-009 SHALL have port txd_in, input, 8: byte to transmit.
REQ-010 SHALL have port txd, output, 1: serial line, idle high.
REQ-011 SHALL have port tx_busy, output, 1: high while a frame is in progress.
REQ-012 SHALL have port tx_done, output, 1: one-clk pulse when the stop bit completes.

Function
REQ-013 SHALL generate tick = sample_clk & ~sample_clk_d, where sample_clk_d is sample_clk registered on clk, and SHALL advance the bit timer only when tick=1 and tx_en=1.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter (0..OVERSAMPLE-1) and a 3-bit data-bit counter.
REQ-015 SHALL, in IDLE with tx_en=1 and tx_start=1, latch txd_in into a shift register and latch the parity mode, then enter START on the next clk; txd SHALL go 0 on that same edge.
REQ-016 SHALL ignore tx_start while tx_busy=1; the latched data and mode SHALL be unaffected.
REQ-017 SHALL hold each bit on txd for exactly OVERSAMPLE ticks, then advance state or bit on the clk edge of the last tick.
REQ-018 SHALL send data LSB first in DATA; after bit 7 SHALL go to PARITY if the latched no_parity=0, else to STOP.
REQ-019 SHALL drive the parity bit as XOR(data) for even parity and ~XOR(data) for odd parity, making the total count of ones across data+parity even or odd respectively.
REQ-020 SHALL drive txd=1 in STOP for one bit period, then return to IDLE, pulse tx_done for one clk, and deassert tx_busy on the same edge.
REQ-021 SHALL allow a tx_start in the clk after tx_done to begin the next frame with no extra idle bit.
REQ-022 SHALL assert tx_busy from the clk edge that accepts tx_start until the end of STOP.
REQ-023 SHALL, when tx_en=0 in any state, return to IDLE on the next clk: txd=1, tx_busy=0, counters cleared, no tx_done pulse.
REQ-024 SHALL keep txd a registered output (glitch-free), and SHALL keep txd=1 in IDLE.
REQ-025 SHALL not apply changes to no_parity or ev_parity mid-frame; the latched values SHALL be used.

Reset
REQ-026 SHALL, while rst_n=0, force: state=IDLE, txd=1, tx_busy=0, tx_done=0, counters=0, shift register=8'hFF, sample_clk_d=0.
REQ-027 SHALL, on rst_n assertion mid-frame, abort the frame immediately (asynchronously) with no tx_done pulse.

Verification
REQ-028 SHALL cover: no_parity=1, txd_in=8'h55 -> txd = 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks; frame length 160 ticks; one tx_done pulse.
REQ-029 SHALL cover: even parity, txd_in=8'h07 -> parity bit=1; odd parity, txd_in=8'h03 -> parity bit=1; frame length 176 ticks.
REQ-030 SHALL cover: tx_start pulsed mid-frame with txd_in=8'hAA during a 8'h0F frame -> the frame still carries 8'h0F and 8'hAA is never sent.
REQ-031 SHALL cover: tx_en dropped during DATA bit 3 -> txd=1 and tx_busy=0 one clk later, no tx_done; the next tx_start sends a full correct frame.
REQ-032 SHALL cover: back-to-back tx_start the clk after tx_done with 8'h01 then 8'h80 -> stop bit of frame 1 is followed directly by the start bit of frame 2.
REQ-033 SHALL cover: rst_n pulsed low during PARITY -> all outputs at reset values within the same clk; txd=1.
